// File: rtl/mux_pipe.sv
// N-way channel select feeding a two-entry skid buffer (main + skid), with
// poison substitution and error accounting for out-of-range selects.
module mux_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned N      = 3,
  parameter logic [31:0] POISON = 32'h0000CAFE,
  localparam int unsigned SEL_W = (N > 2) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N*WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_err,
  output logic               err_sticky,
  output logic [7:0]         err_count,
  input  logic               err_clear
);

  localparam logic [WIDTH-1:0] POISON_W = WIDTH'(POISON);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic             main_err_q, main_err_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             skid_err_q, skid_err_d;
  logic             err_sticky_q, err_sticky_d;
  logic [7:0]       err_count_q, err_count_d;

  logic             accept;
  logic             deliver;
  logic [WIDTH-1:0] beat_data;
  logic             beat_err;

  // Channel select; anything outside 0..N-1 falls through to the poison value.
  always_comb begin
    beat_data = POISON_W;
    beat_err  = 1'b1;
    for (int unsigned k = 0; k < N; k++) begin
      if (sel == SEL_W'(k)) begin
        beat_data = in_data[k*WIDTH +: WIDTH];
        beat_err  = 1'b0;
      end
    end
  end

  assign accept  = in_valid & in_ready_q;
  assign deliver = out_valid_q & out_ready;

  // Next-state, datapath moves and error accounting.
  always_comb begin
    state_d      = state_q;
    main_data_d  = main_data_q;
    main_err_d   = main_err_q;
    skid_data_d  = skid_data_q;
    skid_err_d   = skid_err_q;
    err_sticky_d = err_sticky_q;
    err_count_d  = err_count_q;

    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d     = ONE;
          main_data_d = beat_data;
          main_err_d  = beat_err;
        end
      end
      ONE: begin
        if (accept && deliver) begin
          main_data_d = beat_data;
          main_err_d  = beat_err;
        end else if (accept) begin
          state_d     = TWO;
          skid_data_d = beat_data;
          skid_err_d  = beat_err;
        end else if (deliver) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (deliver) begin
          state_d     = ONE;
          main_data_d = skid_data_q;
          main_err_d  = skid_err_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    // An illegal accept wins over a simultaneous clear and counts as the first.
    if (accept && beat_err) begin
      err_sticky_d = 1'b1;
      if (err_clear) begin
        err_count_d = 8'd1;
      end else if (err_count_q != 8'hFF) begin
        err_count_d = 8'(err_count_q + 8'd1);
      end
    end else if (err_clear) begin
      err_sticky_d = 1'b0;
      err_count_d  = 8'd0;
    end

    in_ready_d  = (state_d != TWO);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= EMPTY;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      main_data_q  <= '0;
      main_err_q   <= 1'b0;
      skid_data_q  <= '0;
      skid_err_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      err_count_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      main_data_q  <= main_data_d;
      main_err_q   <= main_err_d;
      skid_data_q  <= skid_data_d;
      skid_err_q   <= skid_err_d;
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = main_data_q;
  assign out_err    = main_err_q;
  assign err_sticky = err_sticky_q;
  assign err_count  = err_count_q;

endmodule

// File: doc/mux_pipe.md
MUX_PIPE -- requirements
Module: mux_pipe

Interface
REQ-001 Parameter WIDTH, default 32, sets the bit width of each data channel.
REQ-002 Parameter N, default 3, sets the number of input channels; legal values are 2..16.
REQ-003 Parameter POISON, default 32'h0000CAFE, is the value driven for an illegal select, truncated or zero-extended to WIDTH.
REQ-004 Local SEL_W SHALL equal $clog2(N), with a minimum of 1.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 in_valid  in  1  upstream beat present.
REQ-008 in_ready  out  1  block can accept a beat this cycle.
REQ-009 sel  in  SEL_W  channel select, sampled with the beat.
REQ-010 in_data  in  N*WIDTH  packed channels; channel k is in_data[k*WIDTH +: WIDTH].
REQ-011 out_valid  out  1  output beat present.
REQ-012 out_ready  in  1  downstream accepts the beat.
REQ-013 out_data  out  WIDTH  selected channel, or POISON.
REQ-014 out_err  out  1  beat-aligned flag: the current out_data came from an illegal select.
REQ-015 err_sticky  out  1  at least one illegal select has been accepted since reset or the last clear.
REQ-016 err_count  out  8  count of accepted illegal selects, saturating.
REQ-017 err_clear  in  1  synchronous clear of err_sticky and err_count.

Function
REQ-018 A beat SHALL be accepted in any cycle where in_valid and in_ready are both 1; a beat SHALL be delivered in any cycle where out_valid and out_ready are both 1.
REQ-019 Datapath: a main output register plus one skid register, 2 entries total, strictly FIFO-ordered.
REQ-020 States: EMPTY (0 entries), ONE (main full), TWO (main and skid full).
REQ-021 Transitions: EMPTY->ONE on accept; ONE->TWO on accept with no deliver; ONE->EMPTY on deliver with no accept; ONE->ONE on simultaneous accept and deliver; TWO->ONE on deliver (skid moves to main); all other cases hold state.
REQ-022 in_ready SHALL equal 1 in EMPTY and ONE, and 0 in TWO; it SHALL be a registered signal with no combinational path from out_ready.
REQ-023 out_valid SHALL be 1 exactly in ONE and TWO; out_data and out_err SHALL come from the main register only.
REQ-024 Latency: a beat accepted in cycle t into EMPTY SHALL appear on out_data in cycle t+1.
REQ-025 Beats held while out_valid=1 and out_ready=0 SHALL remain stable until delivered.
REQ-026 Legal sel (sel<N): the stored data SHALL be channel sel at the accept edge, with err bit 0.
REQ-027 Illegal sel (sel>=N, possible only when N is not a power of two): the stored data SHALL be POISON with err bit 1.
REQ-028 On each accepted illegal beat, err_sticky SHALL be set and err_count SHALL increment, holding at 255.
REQ-029 err_clear with no simultaneous illegal accept SHALL zero err_sticky and err_count next cycle.
REQ-030 err_clear with a simultaneous illegal accept SHALL leave err_sticky=1 and err_count=1.
REQ-031 Beats not accepted, including those with in_valid=1 while in_ready=0, SHALL NOT affect the error counters.
REQ-032 sel and in_data SHALL be ignored when in_valid=0; the design SHALL contain no simulation-only output side effects.

Reset
REQ-033 Asserting rst SHALL immediately force EMPTY, out_valid=0, in_ready=1, out_data=0, out_err=0, err_sticky=0, err_count=0, regardless of clk.
REQ-034 Reset mid-transfer SHALL discard all held beats; the first accept after rst deasserts SHALL behave as from EMPTY.

Verification
REQ-035 Scenario: N=3, in_data = {C2=3, C1=2, C0=1}, sel=1, one beat, out_ready=1 -> out_data=2 one cycle later, out_err=0, then out_valid=0.
REQ-036 Scenario: N=3, sel=3 accepted -> out_data=0x0000CAFE, out_err=1, err_sticky=1, err_count=1.
REQ-037 Scenario: out_ready=0 with beats A=0x11 then B=0x22 -> in_ready=0 after B; release -> A then B in order, in_ready=1 after A is delivered.
REQ-038 Scenario: continuous in_valid and out_ready=1 -> one beat per cycle, in_ready stays 1, no data loss.
REQ-039 Scenario: 260 illegal beats -> err_count=255; err_clear together with an illegal beat -> err_count=1.
REQ-040 Scenario: rst pulse while in TWO with no clk edge -> out_valid=0 and in_ready=1 immediately; held beats never appear.
